// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the load/store unit (port 0) and a debug/DMA
// master (port 1); one captured access at a time, read data returned with a per-port rvalid.
module dmem_arbiter #(
    parameter int unsigned PRIORITY_MODE = 0,
    parameter int unsigned ADDR_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p1_req,
    input  logic              p0_we,
    input  logic              p1_we,
    input  logic [3:0]        p0_mask,
    input  logic [3:0]        p1_mask,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p0_wdata,
    input  logic [31:0]       p1_wdata,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic [31:0]       p0_rdata,
    output logic [31:0]       p1_rdata,
    output logic              p0_stall,
    output logic              mem_request,
    output logic              mem_we_re,
    output logic              mem_load,
    output logic [3:0]        mem_mask,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    input  logic              mem_valid,
    input  logic [31:0]       mem_data_out
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e              state_q, state_d;
    logic                last_grant_q;  // 1 = port 1 was granted most recently
    logic                owner_q;
    logic                we_q;
    logic [3:0]          mask_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;

    logic                any_req;
    logic                winner;
    logic                take;
    logic                sel_we;
    logic [3:0]          sel_mask;
    logic [ADDR_W-1:0]   sel_addr;
    logic [31:0]         sel_wdata;

    always_comb begin
        any_req = p0_req | p1_req;
        if (p0_req && p1_req) begin
            winner = (PRIORITY_MODE != 0) ? 1'b0 : ~last_grant_q;
        end else begin
            winner = p1_req;
        end
        take      = (state_q == StIdle) && any_req;
        sel_we    = winner ? p1_we    : p0_we;
        sel_mask  = winner ? p1_mask  : p0_mask;
        sel_addr  = winner ? p1_addr  : p0_addr;
        sel_wdata = winner ? p1_wdata : p0_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            mask_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                last_grant_q <= winner;
                owner_q      <= winner;
                we_q         <= sel_we;
                mask_q       <= sel_mask;
                addr_q       <= sel_addr;
                wdata_q      <= sel_wdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (any_req) state_d = StAccess;
            StAccess: state_d = we_q ? StIdle : StResp;
            StResp:   if (mem_valid) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Grants are gated by rst so nothing is granted while reset is held.
    always_comb begin
        p0_gnt      = 1'b0;
        p1_gnt      = 1'b0;
        p0_rvalid   = 1'b0;
        p1_rvalid   = 1'b0;
        p0_rdata    = '0;
        p1_rdata    = '0;
        mem_request = 1'b0;
        mem_we_re   = 1'b0;
        mem_load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rst && any_req) begin
                    p0_gnt = ~winner;
                    p1_gnt = winner;
                end
            end
            StAccess: begin
                mem_request = 1'b1;
                mem_we_re   = we_q;
                mem_load    = ~we_q;
            end
            StResp: begin
                if (mem_valid) begin
                    p0_rvalid = ~owner_q;
                    p1_rvalid = owner_q;
                    p0_rdata  = owner_q ? 32'h0 : mem_data_out;
                    p1_rdata  = owner_q ? mem_data_out : 32'h0;
                end
            end
            default: ;
        endcase
        p0_stall = rst & p0_req & ~p0_gnt;
    end

    assign mem_mask    = mask_q;
    assign mem_address = addr_q;
    assign mem_data_in = wdata_q;

endmodule
